up_down_sweep_controller: RTL and testbench



---
 rtl/up_down_sweep_controller_if.sv | 32 +++
 rtl/up_down_sweep_controller.sv | 130 +++++++++++++
 tb/tb_up_down_sweep_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/up_down_sweep_controller_if.sv
// Bundles the sweep controller's command, configuration and status signals.
//   start/stop        : run request / abort
//   lo/hi/dwell/sweeps: run configuration, latched when a start is accepted
//   count/down/busy/done/err : registered status from the controller
// Modports: master (stimulus side) and slave (the controller).
interface up_down_sweep_controller_if #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned SWEEP_W = 4
);
  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi;
  logic [DWELL_W-1:0] dwell;
  logic [SWEEP_W-1:0] sweeps;
  logic [WIDTH-1:0]   count;
  logic               down;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, stop, lo, hi, dwell, sweeps,
    input  count, down, busy, done, err
  );

  modport slave (
    input  start, stop, lo, hi, dwell, sweeps,
    output count, down, busy, done, err
  );
endinterface

// File: rtl/up_down_sweep_controller.sv
// Triangle-sweep sequencer owning a count register: lo->hi, dwell at hi,
// hi->lo, dwell at lo, repeated `sweeps` times (0 = until stop).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of up_down_sweep_controller_if
//          (start, stop, lo, hi, dwell, sweeps in; count, down, busy, done, err out)
module up_down_sweep_controller #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned SWEEP_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  up_down_sweep_controller_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE
  } state_t;

  localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [SWEEP_W-1:0] SWEEP_ONE = SWEEP_W'(1);

  state_t             state;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [SWEEP_W-1:0] sweeps_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [SWEEP_W-1:0] sweep_cnt;

  // Status outputs are registered together with the state they describe,
  // so every transition below sets busy/down/done for the state it enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      dwell_q   <= '0;
      sweeps_q  <= '0;
      dwell_cnt <= '0;
      sweep_cnt <= '0;
      bus.count <= '0;
      bus.down  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.stop) begin
        // Abort wins over everything, including a simultaneous start in IDLE.
        state    <= IDLE;
        bus.busy <= 1'b0;
        bus.down <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              lo_q     <= bus.lo;
              hi_q     <= bus.hi;
              dwell_q  <= bus.dwell;
              sweeps_q <= bus.sweeps;
              bus.err  <= (bus.lo >= bus.hi);
              if (bus.lo < bus.hi) begin
                bus.count <= bus.lo;
                sweep_cnt <= '0;
                state     <= UP;
                bus.busy  <= 1'b1;
                bus.down  <= 1'b0;
              end
            end
          end
          UP: begin
            if (bus.count == hi_q) begin
              dwell_cnt <= dwell_q;
              state     <= DWELL_HI;
              bus.down  <= 1'b1;
            end else begin
              bus.count <= bus.count + CNT_ONE;
            end
          end
          DWELL_HI: begin
            if (dwell_cnt == '0) begin
              bus.count <= hi_q - CNT_ONE;
              state     <= DOWN;
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_ONE;
            end
          end
          DOWN: begin
            if (bus.count == lo_q) begin
              dwell_cnt <= dwell_q;
              state     <= DWELL_LO;
              bus.down  <= 1'b0;
            end else begin
              bus.count <= bus.count - CNT_ONE;
            end
          end
          DWELL_LO: begin
            if (dwell_cnt == '0) begin
              if (sweeps_q != '0 && (sweep_cnt + SWEEP_ONE) == sweeps_q) begin
                state    <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end else begin
                // lo was already shown in DOWN and DWELL_LO, so restart above it.
                sweep_cnt <= sweep_cnt + SWEEP_ONE;
                bus.count <= lo_q + CNT_ONE;
                state     <= UP;
              end
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_ONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.down <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_up_down_sweep_controller.sv
module tb_up_down_sweep_controller;

  logic clk;
  logic rst;

  up_down_sweep_controller_if #(.WIDTH(4), .DWELL_W(4), .SWEEP_W(4)) bus ();

  up_down_sweep_controller #(.WIDTH(4), .DWELL_W(4), .SWEEP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected per-cycle observation: {count[3:0], down, busy, done}
  logic [6:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  function automatic void push(input int v, input bit dn, input bit fin);
    logic [3:0] c;
    c = v[3:0];
    exp_q.push_back({c, dn, ~fin, fin});
  endfunction

  // Reference trace built from the sweep rules: each sweep shows lo..hi going up,
  // hi for dwell+1 more cycles, hi-1..lo going down, lo for dwell+1 more cycles.
  function automatic void push_trace(input int l, input int h, input int d,
                                     input int n, input bit finite);
    for (int s = 0; s < n; s++) begin
      for (int v = (s == 0) ? l : l + 1; v <= h; v++) push(v, 1'b0, 1'b0);
      for (int k = 0; k <= d; k++) push(h, 1'b1, 1'b0);
      for (int v = h - 1; v >= l; v--) push(v, 1'b1, 1'b0);
      for (int k = 0; k <= d; k++) push(l, 1'b0, 1'b0);
    end
    if (finite) push(l, 1'b0, 1'b1);
  endfunction

  // Monitor: every busy or done cycle must match the next expected observation.
  always @(negedge clk) begin
    if (!rst && (bus.busy || bus.done)) begin
      if (exp_q.size() == 0)
        check("unexpected_output", {25'd0, bus.count, bus.down, bus.busy, bus.done}, 32'hffff_ffff);
      else
        check("trace", {25'd0, bus.count, bus.down, bus.busy, bus.done}, {25'd0, exp_q.pop_front()});
    end
  end

  task automatic do_start(input int l, input int h, input int d, input int s);
    bus.lo     = l[3:0];
    bus.hi     = h[3:0];
    bus.dwell  = d[3:0];
    bus.sweeps = s[3:0];
    bus.start  = 1'b1;
    @(negedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // Wait for the scoreboard to empty while scrambling config inputs and
  // pulsing start; start is only raised while the DUT stays busy/DONE next edge.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      if (n == 3000) begin
        fail_now("drain_timeout");
        exp_q.delete();
        break;
      end
      bus.lo     = 4'($urandom);
      bus.hi     = 4'($urandom);
      bus.dwell  = 4'($urandom);
      bus.sweeps = 4'($urandom);
      bus.start  = 1'($urandom);
      @(negedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
  endtask

  task automatic run(input int l, input int h, input int d, input int s);
    push_trace(l, h, d, s, 1'b1);
    do_start(l, h, d, s);
    check("err_clear", {31'd0, bus.err}, 32'd0);
    drain();
    @(negedge clk); #1;
    check("idle_after_done", {26'd0, bus.count, bus.busy, bus.done}, {26'd0, 4'(l), 2'b00});
  endtask

  initial begin
    int c;
    int l;
    int h;
    int n;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.lo     = '0;
    bus.hi     = '0;
    bus.dwell  = '0;
    bus.sweeps = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", {24'd0, bus.count, bus.down, bus.busy, bus.done, bus.err}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_after_reset", {24'd0, bus.count, bus.down, bus.busy, bus.done, bus.err}, 32'd0);

    run(2, 4, 1, 1);
    run(0, 15, 0, 2);
    run(14, 15, 2, 3);

    // Bad config: lo == hi
    c = int'(bus.count);
    do_start(5, 5, 0, 1);
    check("err_set", {30'd0, bus.err, bus.busy}, 32'd2);
    check("err_count_held", 32'(bus.count), 32'(c));
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", {31'd0, bus.err}, 32'd1);

    // start and stop together in IDLE: ignored, err untouched
    bus.lo = 4'd0; bus.hi = 4'd9; bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    check("start_stop_idle", {26'd0, bus.count, bus.busy, bus.err}, {26'd0, 4'(c), 2'b01});

    run(1, 3, 0, 1);

    // Endless run: 21 full sweeps, then stop while DOWN shows 4
    push_trace(3, 6, 0, 21, 1'b0);
    push(4, 1'b0, 1'b0); push(5, 1'b0, 1'b0); push(6, 1'b0, 1'b0);
    push(6, 1'b1, 1'b0); push(5, 1'b1, 1'b0); push(4, 1'b1, 1'b0);
    do_start(3, 6, 0, 0);
    drain();
    bus.stop = 1'b1;
    @(negedge clk); #1;
    bus.stop = 1'b0;
    check("stop_state", {25'd0, bus.count, bus.down, bus.busy, bus.done}, {25'd0, 4'd4, 3'b000});
    repeat (2) @(negedge clk);
    #1;
    check("stop_no_done", {25'd0, bus.count, bus.down, bus.busy, bus.done}, {25'd0, 4'd4, 3'b000});

    // Asynchronous reset during the dwell at hi
    push_trace(1, 5, 5, 1, 1'b1);
    do_start(1, 5, 5, 1);
    n = 0;
    while (!bus.down && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n == 50) fail_now("wait_dwell_hi");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_reset", {24'd0, bus.count, bus.down, bus.busy, bus.done, bus.err}, 32'd0);
    exp_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    run(1, 3, 1, 2);

    // Randomized configurations
    for (int i = 0; i < 10; i++) begin
      l = int'($urandom_range(0, 14));
      h = int'($urandom_range(l + 1, 15));
      run(l, h, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
